// File: rtl/iob_axistream_in.sv
// AXI-Stream sink on the IOb native bus: packs TDATA_W-bit samples little-endian
// into 32-bit words, tags each with {last, nbytes} and queues them for CPU reads.
module iob_axistream_in #(
  parameter int TDATA_W         = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [TDATA_W-1:0]  tdata,
  input  logic                tvalid,
  output logic                tready,
  input  logic                tlast
);

  localparam int N     = 32 / TDATA_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int BPS   = TDATA_W / 8;

  typedef enum logic [ADDR_W-1:0] {
    REG_DATA   = ADDR_W'(0),
    REG_STATUS = ADDR_W'(1),
    REG_CTRL   = ADDR_W'(2),
    REG_RSVD   = ADDR_W'(3)
  } reg_addr_t;

  logic [31:0]                mem_data [DEPTH];
  logic                       mem_last [DEPTH];
  logic [2:0]                 mem_nb   [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr, rptr;
  logic [LVL_W-1:0]           level;
  logic [CNT_W-1:0]           cnt;
  logic [31:0]                pack;
  logic                       underflow;

  logic        empty, full, rd_req, flush, accept, word_done, push, pop;
  logic [31:0] push_data;
  logic [2:0]  push_nb;
  logic [31:0] status;
  logic [DATA_W-1:0] rd_mux;
  logic        unused_wdata;

  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(DEPTH));
  assign tready    = ~full;
  assign rd_req    = valid && (wstrb == '0);
  assign flush     = valid && (wstrb != '0) && (address == REG_CTRL) && wdata[0];
  // A flush in the same cycle as a handshake drops the sample.
  assign accept    = tvalid && tready && !flush;
  assign word_done = (cnt == CNT_W'(N - 1)) || tlast;
  assign push      = accept && word_done;
  assign pop       = rd_req && (address == REG_DATA) && !empty;
  assign push_data = pack | (32'(tdata) << (int'(cnt) * TDATA_W));
  assign push_nb   = 3'((int'(cnt) + 1) * BPS);
  assign unused_wdata = ^wdata[DATA_W-1:1];

  always_comb begin
    status      = '0;
    status[0]   = empty;
    status[1]   = full;
    status[2]   = empty ? 1'b0 : mem_last[rptr];
    status[5:3] = empty ? 3'd0 : mem_nb[rptr];
    status[6]   = underflow;
    status[15:8] = 8'(level);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_DATA:   rd_mux = empty ? '0 : DATA_W'(mem_data[rptr]);
      REG_STATUS: rd_mux = DATA_W'(status);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      cnt       <= '0;
      pack      <= '0;
      underflow <= 1'b0;
      ready     <= 1'b0;
      rdata     <= '0;
    end else begin
      ready <= valid;
      rdata <= rd_req ? rd_mux : '0;
      if (flush) begin
        wptr      <= '0;
        rptr      <= '0;
        level     <= '0;
        cnt       <= '0;
        pack      <= '0;
        underflow <= 1'b0;
      end else begin
        if (rd_req && (address == REG_DATA) && empty) underflow <= 1'b1;
        if (accept) begin
          if (word_done) begin
            cnt  <= '0;
            pack <= '0;
          end else begin
            cnt  <= cnt + 1'b1;
            pack <= push_data;
          end
        end
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        level <= level + LVL_W'(push) - LVL_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= push_data;
      mem_last[wptr] <= tlast;
      mem_nb[wptr]   <= push_nb;
    end
  end

endmodule

// File: tb/tb_iob_axistream_in.sv
// Bench for iob_axistream_in: an 8-bit and a 16-bit instance checked every cycle
// against a queue-based model, plus literal expectations for key transactions.
module tb_iob_axistream_in;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_s  [2];
  logic [1:0]  addr_s   [2];
  logic [31:0] wdata_s  [2];
  logic [3:0]  wstrb_s  [2];
  logic [15:0] tdata_s  [2];
  logic        tvalid_s [2];
  logic        tlast_s  [2];

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, tready0, tready1;

  int errors = 0;
  int checks = 0;

  iob_axistream_in #(.TDATA_W(8), .FIFO_DEPTH_LOG2(4), .DATA_W(32), .ADDR_W(2)) dut0 (
    .clk(clk), .rst(rst), .valid(valid_s[0]), .address(addr_s[0]), .wdata(wdata_s[0]),
    .wstrb(wstrb_s[0]), .rdata(rdata0), .ready(ready0), .tdata(tdata_s[0][7:0]),
    .tvalid(tvalid_s[0]), .tready(tready0), .tlast(tlast_s[0])
  );

  iob_axistream_in #(.TDATA_W(16), .FIFO_DEPTH_LOG2(4), .DATA_W(32), .ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .valid(valid_s[1]), .address(addr_s[1]), .wdata(wdata_s[1]),
    .wstrb(wstrb_s[1]), .rdata(rdata1), .ready(ready1), .tdata(tdata_s[1]),
    .tvalid(tvalid_s[1]), .tready(tready1), .tlast(tlast_s[1])
  );

  // Model: a queue of tagged words and a list of pending samples per instance.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int W = (g == 0) ? 8 : 16;
    localparam int N = 32 / W;
    logic [31:0] q_data [$];
    bit          q_last [$];
    int          q_nb   [$];
    logic [31:0] part   [$];
    bit          uflow;
    logic        exp_ready, exp_tready;
    logic [31:0] exp_rdata;

    always @(posedge clk) begin
      logic [31:0] resp, word, st;
      bit acc, flush;
      int sz;
      resp = '0;
      if (rst) begin
        q_data.delete(); q_last.delete(); q_nb.delete(); part.delete();
        uflow      <= 1'b0;
        exp_ready  <= 1'b0;
        exp_rdata  <= '0;
        exp_tready <= 1'b1;
      end else begin
        sz    = q_data.size();
        acc   = tvalid_s[g] && (sz < DEPTH);
        flush = valid_s[g] && (wstrb_s[g] != 0) && (addr_s[g] == 2'd2) && wdata_s[g][0];
        if (valid_s[g] && wstrb_s[g] == 0) begin
          if (addr_s[g] == 2'd0) begin
            if (sz == 0) uflow <= 1'b1;
            else begin
              resp = q_data.pop_front();
              void'(q_last.pop_front());
              void'(q_nb.pop_front());
            end
          end else if (addr_s[g] == 2'd1) begin
            st = '0;
            st[0] = (sz == 0);
            st[1] = (sz == DEPTH);
            if (sz != 0) begin
              st[2]   = q_last[0];
              st[5:3] = 3'(q_nb[0]);
            end
            st[6]    = uflow;
            st[15:8] = 8'(sz);
            resp = st;
          end
        end
        if (flush) begin
          q_data.delete(); q_last.delete(); q_nb.delete(); part.delete();
          uflow <= 1'b0;
        end else if (acc) begin
          part.push_back(32'(tdata_s[g][W-1:0]));
          if (part.size() == N || tlast_s[g]) begin
            word = '0;
            for (int i = 0; i < part.size(); i++) word |= part[i] << (i * W);
            q_data.push_back(word);
            q_last.push_back(tlast_s[g]);
            q_nb.push_back(part.size() * W / 8);
            part.delete();
          end
        end
        exp_ready  <= valid_s[g];
        exp_rdata  <= resp;
        exp_tready <= (q_data.size() < DEPTH);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("d0_tready", 32'(tready0), 32'(mdl[0].exp_tready));
    chk("d0_ready",  32'(ready0),  32'(mdl[0].exp_ready));
    chk("d0_rdata",  rdata0,       mdl[0].exp_rdata);
    chk("d1_tready", 32'(tready1), 32'(mdl[1].exp_tready));
    chk("d1_ready",  32'(ready1),  32'(mdl[1].exp_ready));
    chk("d1_rdata",  rdata1,       mdl[1].exp_rdata);
  endtask

  function automatic logic [31:0] rd(int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  function automatic logic trdy(int d);
    return (d == 0) ? tready0 : tready1;
  endfunction

  task automatic cpu_req(int d, logic [1:0] a, logic [31:0] wd, logic [3:0] ws);
    valid_s[d] = 1'b1;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    wstrb_s[d] = ws;
  endtask

  task automatic cpu_read(int d, logic [1:0] a, output logic [31:0] v);
    cpu_req(d, a, '0, 4'h0);
    tick();
    v = rd(d);
    valid_s[d] = 1'b0;
  endtask

  task automatic cpu_write(int d, logic [1:0] a, logic [31:0] wd);
    cpu_req(d, a, wd, 4'hf);
    tick();
    valid_s[d] = 1'b0;
    wstrb_s[d] = 4'h0;
  endtask

  task automatic send(int d, logic [15:0] s, logic l);
    int unsigned budget = 0;
    while (!trdy(d) && budget < 50) begin
      tick();
      budget++;
    end
    if (!trdy(d)) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: got tready=0 expected 1", d);
    end else begin
      tvalid_s[d] = 1'b1;
      tdata_s[d]  = s;
      tlast_s[d]  = l;
      tick();
      tvalid_s[d] = 1'b0;
      tlast_s[d]  = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      valid_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0; wstrb_s[d] = '0;
      tdata_s[d] = '0; tvalid_s[d] = 1'b0; tlast_s[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset_ready",  32'(ready0),  32'd0);
    chk("reset_rdata",  rdata0,       32'd0);
    chk("reset_tready", 32'(tready0), 32'd1);
    cpu_read(0, 2'd1, v); chk("reset_status", v, 32'h0000_0001);

    // Full 4-byte frame
    send(0, 16'h11, 1'b0); send(0, 16'h22, 1'b0); send(0, 16'h33, 1'b0); send(0, 16'h44, 1'b1);
    cpu_read(0, 2'd1, v); chk("frame4_status", v, 32'h0000_0124);
    cpu_read(0, 2'd0, v); chk("frame4_data", v, 32'h4433_2211);
    cpu_read(0, 2'd1, v); chk("frame4_empty", v, 32'h0000_0001);

    // Partial 2-byte frame
    send(0, 16'hAA, 1'b0); send(0, 16'hBB, 1'b1);
    cpu_read(0, 2'd1, v); chk("frame2_status", v, 32'h0000_0114);
    cpu_read(0, 2'd0, v); chk("frame2_data", v, 32'h0000_BBAA);

    // Fill to full, drain one, add a 17th word
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 4; k++) send(0, 16'(w * 4 + k + 1), 1'b0);
    chk("full_tready", 32'(tready0), 32'd0);
    cpu_read(0, 2'd1, v); chk("full_status", v, 32'h0000_1022);
    cpu_read(0, 2'd0, v); chk("full_first", v, 32'h0403_0201);
    chk("after_pop_tready", 32'(tready0), 32'd1);
    send(0, 16'hA0, 1'b0); send(0, 16'hA1, 1'b0); send(0, 16'hA2, 1'b0); send(0, 16'hA3, 1'b1);
    cpu_read(0, 2'd0, v); chk("order_second", v, 32'h0807_0605);
    for (int i = 0; i < 14; i++) cpu_read(0, 2'd0, v);
    cpu_read(0, 2'd0, v); chk("order_17th", v, 32'hA3A2_A1A0);

    // Underflow and flush
    cpu_read(0, 2'd0, v); chk("underflow_data", v, 32'd0);
    cpu_read(0, 2'd1, v); chk("underflow_status", v, 32'h0000_0041);
    cpu_write(0, 2'd2, 32'h1);
    cpu_read(0, 2'd1, v); chk("flush_status", v, 32'h0000_0001);
    cpu_read(0, 2'd2, v); chk("ctrl_read", v, 32'd0);

    // Flush mid-word, racing a sample that must be dropped
    send(0, 16'h55, 1'b0); send(0, 16'h66, 1'b0); send(0, 16'h77, 1'b0);
    cpu_req(0, 2'd2, 32'h1, 4'hf);
    tvalid_s[0] = 1'b1; tdata_s[0] = 16'h99;
    tick();
    valid_s[0] = 1'b0; wstrb_s[0] = 4'h0; tvalid_s[0] = 1'b0;
    cpu_read(0, 2'd1, v); chk("flush_mid_status", v, 32'h0000_0001);
    send(0, 16'h01, 1'b0); send(0, 16'h02, 1'b0); send(0, 16'h03, 1'b0); send(0, 16'h04, 1'b1);
    cpu_read(0, 2'd0, v); chk("flush_mid_data", v, 32'h0403_0201);

    // DATA read on empty FIFO while a word is pushed
    send(0, 16'hC1, 1'b0); send(0, 16'hC2, 1'b0); send(0, 16'hC3, 1'b0);
    cpu_req(0, 2'd0, '0, 4'h0);
    tvalid_s[0] = 1'b1; tdata_s[0] = 16'hC4;
    tick();
    v = rdata0;
    valid_s[0] = 1'b0; tvalid_s[0] = 1'b0;
    chk("empty_race_data", v, 32'd0);
    cpu_read(0, 2'd1, v); chk("empty_race_status", v, 32'h0000_0160);
    cpu_read(0, 2'd0, v); chk("empty_race_word", v, 32'hC4C3_C2C1);
    cpu_write(0, 2'd2, 32'h1);

    // Reset mid-frame
    send(0, 16'hE1, 1'b0); send(0, 16'hE2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(0, 16'h31, 1'b0); send(0, 16'h32, 1'b0); send(0, 16'h33, 1'b0); send(0, 16'h34, 1'b1);
    cpu_read(0, 2'd0, v); chk("rst_mid_data", v, 32'h3433_3231);

    // 16-bit instance: push and pop in the same cycle
    send(1, 16'hAAAA, 1'b0); send(1, 16'hBBBB, 1'b0);
    send(1, 16'h1234, 1'b0);
    cpu_req(1, 2'd0, '0, 4'h0);
    tvalid_s[1] = 1'b1; tdata_s[1] = 16'h5678; tlast_s[1] = 1'b1;
    tick();
    v = rdata1;
    valid_s[1] = 1'b0; tvalid_s[1] = 1'b0; tlast_s[1] = 1'b0;
    chk("w16_prev_data", v, 32'hBBBB_AAAA);
    cpu_read(1, 2'd1, v); chk("w16_status", v, 32'h0000_0124);
    cpu_read(1, 2'd0, v); chk("w16_data", v, 32'h5678_1234);
    cpu_write(1, 2'd3, 32'hFFFF_FFFF);
    cpu_read(1, 2'd3, v); chk("w16_reserved", v, 32'd0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iob_axistream_in.md
Name: iob_axistream_in

Overview:
AXI-Stream receiver peripheral on the IOb native CPU bus. Accepts TDATA_W-bit samples, packs them little-endian into 32-bit words and buffers them in a word FIFO the CPU drains by register reads. It is the sink counterpart of the axistream_out transmitter: a frame sent there, terminated by TLAST, is recovered here word by word. The valid-byte count of the final, possibly partial, word is reported.

Parameters:
TDATA_W, 8, stream sample width; must be 8, 16 or 32. N=32/TDATA_W samples per word.
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words.
DATA_W, 32, CPU data width; fixed at 32.
ADDR_W, 2, CPU word-address width.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid  input  1  CPU request valid
address  input  ADDR_W  CPU word address
wdata  input  DATA_W  CPU write data
wstrb  input  DATA_W/8  CPU write strobe; 0 means read
rdata  output  DATA_W  CPU read data
ready  output  1  CPU request done
tdata  input  TDATA_W  stream sample
tvalid  input  1  stream sample valid
tready  output  1  receiver can accept a sample
tlast  input  1  final sample of frame

Behaviour:
- Reset: rdata=0, ready=0, tready=1 after reset. FIFO empty, packer cleared, status empty=1.
- Stream handshake: a sample is accepted when tvalid&tready. tready = ~fifo_full, registered-free combinational from level. Words cannot carry over: tready is low whenever level==2^FIFO_DEPTH_LOG2.
- Packer: slot counter cnt (0..N-1). An accepted sample is written to bits [cnt*TDATA_W +: TDATA_W], and cnt then increments.
  - When cnt==N-1, or the sample has tlast=1, the word is pushed in the same cycle with tag {last=tlast, nbytes=(cnt+1)*TDATA_W/8}. cnt then returns to 0 and unused upper bits are zeroed.
- FIFO: entry holds 32 data bits + last bit + 3-bit nbytes (1..4). A push and a pop in the same cycle leave the level unchanged. A push while full cannot occur because tready=0.
- CPU access: one request per valid pulse. ready=1 exactly one cycle after valid; rdata is valid in that cycle and returns to 0 otherwise.
- Register map (word address):
  - 0 DATA (R): returns the head word and pops it. When empty, returns 0, no pop, and sets the sticky underflow bit.
  - 1 STATUS (R): bit0 empty, bit1 full, bit2 head.last, bits[5:3] head.nbytes (0 if empty), bit6 underflow (sticky), bits[15:8] level (zero-extended). All other bits 0.
  - 2 CTRL (W): bit0=1 is a soft flush. It clears the FIFO, the packer (cnt=0, partial word discarded) and underflow in the next cycle; the bit self-clears. Reads return 0.
  - 3 reserved: reads 0, writes ignored.
- Writes to addresses 0 and 1 are ignored but still acknowledged with ready.
- STATUS reflects state before any pop in the same cycle.
- Simultaneous events:
  - Flush and stream handshake in the same cycle: flush wins and the sample is discarded.
  - DATA read and push on an empty FIFO in the same cycle: the read sees empty and returns 0. The pushed word is kept.
- rst mid-frame: the partial word and all FIFO contents are dropped; the next accepted sample starts at slot 0.
- Latency: the last sample of a word is accepted at cycle t; it is visible in STATUS.empty=0 at cycle t+1.
- Level arithmetic uses FIFO_DEPTH_LOG2+1 bits, so it never wraps. FIFO pointers wrap modulo the depth.

Test Plan:
- TDATA_W=8, stream 0x11,0x22,0x33,0x44 (tlast on 0x44), then read STATUS -> bit0=0, bit2=1, nbytes=4, level=1; read DATA -> 0x44332211; then STATUS.empty=1.
- TDATA_W=8, stream 0xAA,0xBB with tlast on 0xBB -> STATUS nbytes=2, last=1; DATA=0x0000BBAA.
- Fill with 16 full words, no reads -> tready=0 and STATUS.full=1. One DATA read -> tready=1 next cycle. A 17th word is accepted and the FIFO order is preserved.
- DATA read when empty -> rdata=0 and STATUS bit6=1. Write CTRL=1 -> bit6=0 and level=0.
- Stream 3 samples with no tlast, then write CTRL=1, then stream 0x01..0x04 with tlast -> DATA=0x04030201 (no stale bytes).
- TDATA_W=16, stream 0x1234,0x5678 (tlast) while a DATA read pops the previous word in the same cycle -> level unchanged, next DATA=0x56781234, nbytes=4.
